// File: rtl/alu_mc_if.sv
// alu_mc_if: start/busy/done handshake plus operand and result bus of alu_mc.
interface alu_mc_if #(
   parameter int WIDTH = 32
);
   logic             start_in;
   logic [WIDTH-1:0] a_in, b_in;
   logic [3:0]       f_in;
   logic             busy_out, done_out;
   logic [WIDTH-1:0] y_out, hi_out;
   logic             c_out, zero, dz_out;
   modport master (
      output start_in, a_in, b_in, f_in,
      input  busy_out, done_out, y_out, hi_out, c_out, zero, dz_out
   );
   modport slave (
      input  start_in, a_in, b_in, f_in,
      output busy_out, done_out, y_out, hi_out, c_out, zero, dz_out
   );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU (logic/add/sub/slt/sltu, shift-add MULU, restoring DIVU).
// DIVU and dz_out are compiled in only when ALU_MC_DIV_EN is defined.
module alu_mc #(
   parameter int WIDTH = 32
) (
   input logic     clk,
   input logic     rst_n,
   alu_mc_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
`ifdef ALU_MC_DIV_EN
   typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
`else
   typedef enum logic {IDLE, MUL} state_t;
`endif
   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d, lo_q, lo_d, op_q, op_d, y_q, y_d, hi_q, hi_d;
   logic             c_q, c_d, zero_q, zero_d, dz_q, dz_d, done_q, done_d;
   logic [WIDTH-1:0] a, b, bsel, alu_y;
   logic [3:0]       f;
   logic [WIDTH:0]   sum, mul_s;
   logic             slt;

   assign a     = bus.a_in;
   assign b     = bus.b_in;
   assign f     = bus.f_in;
   assign bsel  = f[2] ? ~b : b;
   assign sum   = {1'b0, a} + {1'b0, bsel} + {{WIDTH{1'b0}}, f[2]};
   assign slt   = f[2] ? ((a[WIDTH-1] ^ b[WIDTH-1]) ? a[WIDTH-1] : sum[WIDTH-1]) : (a < b);
   assign alu_y = f[1] ? (f[0] ? {{(WIDTH-1){1'b0}}, slt} : sum[WIDTH-1:0])
                       : (f[0] ? a | bsel : a & bsel);
   // shift-add step: add multiplicand when multiplier LSB is set, then shift {acc,lo} right
   assign mul_s = {1'b0, acc_q} + (lo_q[0] ? {1'b0, op_q} : '0);
`ifdef ALU_MC_DIV_EN
   logic [WIDTH:0] div_s, div_r;
   // restoring step: borrow out of div_r means the shifted remainder is kept unchanged
   assign div_s = {acc_q, lo_q[WIDTH-1]};
   assign div_r = div_s - {1'b0, op_q};
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      lo_d    = lo_q;
      op_d    = op_q;
      y_d     = y_q;
      hi_d    = hi_q;
      c_d     = c_q;
      dz_d    = dz_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: if (bus.start_in) begin
            dz_d = 1'b0;
            if (f == 4'b1000) begin
               state_d = MUL;
               cnt_d   = CW'(WIDTH - 1);
               acc_d   = '0;
               lo_d    = a;
               op_d    = b;
            end
`ifdef ALU_MC_DIV_EN
            else if (f == 4'b1010 && |b) begin
               state_d = DIV;
               cnt_d   = CW'(WIDTH - 1);
               acc_d   = '0;
               lo_d    = a;
               op_d    = b;
            end
`endif
            else begin
               done_d = 1'b1;
               y_d    = f[3] ? '0 : alu_y;
               hi_d   = '0;
               c_d    = ~f[3] & f[1] & ~f[0] & sum[WIDTH];
`ifdef ALU_MC_DIV_EN
               if (f == 4'b1010) begin
                  y_d  = '1;
                  hi_d = a;
                  dz_d = 1'b1;
               end
`endif
            end
         end
         MUL: begin
            acc_d = mul_s[WIDTH:1];
            lo_d  = {mul_s[0], lo_q[WIDTH-1:1]};
         end
`ifdef ALU_MC_DIV_EN
         DIV: begin
            acc_d = div_r[WIDTH] ? div_s[WIDTH-1:0] : div_r[WIDTH-1:0];
            lo_d  = {lo_q[WIDTH-2:0], ~div_r[WIDTH]};
         end
`endif
         default: state_d = IDLE;
      endcase
      if (state_q != IDLE) begin
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
            y_d     = lo_d;
            hi_d    = acc_d;
            c_d     = 1'b0;
         end
      end
      zero_d = ~|y_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         lo_q    <= '0;
         op_q    <= '0;
         y_q     <= '0;
         hi_q    <= '0;
         c_q     <= 1'b0;
         zero_q  <= 1'b1;
         dz_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         lo_q    <= lo_d;
         op_q    <= op_d;
         y_q     <= y_d;
         hi_q    <= hi_d;
         c_q     <= c_d;
         zero_q  <= zero_d;
         dz_q    <= dz_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy_out = state_q != IDLE;
   assign bus.done_out = done_q;
   assign bus.y_out    = y_q;
   assign bus.hi_out   = hi_q;
   assign bus.c_out    = c_q;
   assign bus.zero     = zero_q;
   assign bus.dz_out   = dz_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized self-checking bench for alu_mc (WIDTH=32 and WIDTH=8)
// against a plain-arithmetic reference model.
module tb_alu_mc;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   alu_mc_if #(.WIDTH(32)) b32 ();
   alu_mc_if #(.WIDTH(8))  b8 ();
   alu_mc #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
   alu_mc #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // edges = clock edges after the accept edge until results are visible
   function automatic void model(input int w, input logic [3:0] f, input logic [63:0] a, b,
                                 output logic [63:0] y, hi, output logic c, dz, output int edges);
      logic [63:0] m, s;
      longint      sa, sb;
      m  = (64'd1 << w) - 64'd1;
      sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
      y = 0; hi = 0; c = 0; dz = 0; edges = 0;
      case (f)
         4'b0000: y = a & b;
         4'b0001: y = a | b;
         4'b0100: y = a & ~b & m;
         4'b0101: y = (a | ~b) & m;
         4'b0010, 4'b0110: begin
            s = a + (f[2] ? (~b & m) + 64'd1 : b);
            y = s & m;
            c = s[w];
         end
         4'b0111: y = {63'd0, sa < sb};
         4'b0011: y = {63'd0, a < b};
         4'b1000: begin
            s = a * b;
            y = s & m;
            hi = s >> w;
            edges = w;
         end
`ifdef ALU_MC_DIV_EN
         4'b1010: if (b == 0) begin
            y = m; hi = a; dz = 1;
         end else begin
            y = a / b; hi = a % b; edges = w;
         end
`endif
         default: ;
      endcase
   endfunction

   task automatic run32(input logic [3:0] f, input logic [31:0] a, b, input int inject, input bit chk_drop);
      logic [63:0] ey, eh;
      logic        ec, edz;
      int          ee, cyc, busy_n;
      logic [31:0] prev_y;
      model(32, f, {32'd0, a}, {32'd0, b}, ey, eh, ec, edz, ee);
      prev_y = b32.y_out;
      @(negedge clk);
      b32.start_in = 1; b32.f_in = f; b32.a_in = a; b32.b_in = b;
      @(posedge clk); #1;
      b32.start_in = 0;
      cyc = 0; busy_n = 0;
      if (ee > 0) check("hold_y", b32.y_out, prev_y);
      while (!b32.done_out && cyc < 100) begin
         busy_n += int'(b32.busy_out);
         if (cyc == inject) begin
            b32.start_in = 1; b32.f_in = 4'b0000; b32.a_in = '1; b32.b_in = '1;
         end
         @(posedge clk); #1;
         b32.start_in = 0;
         cyc++;
      end
      check($sformatf("latency f=%b", f), cyc, ee);
      check($sformatf("busy_cycles f=%b", f), busy_n, ee);
      check("busy_at_done", b32.busy_out, 0);
      check($sformatf("y f=%b a=%h b=%h", f, a, b), b32.y_out, ey);
      check($sformatf("hi f=%b a=%h b=%h", f, a, b), b32.hi_out, eh);
      check($sformatf("c f=%b", f), b32.c_out, ec);
      check($sformatf("zero f=%b", f), b32.zero, ey == 0);
      check($sformatf("dz f=%b", f), b32.dz_out, edz);
      if (chk_drop) begin
         @(posedge clk); #1;
         check("done_pulse", b32.done_out, 0);
      end
   endtask

   task automatic run8(input logic [3:0] f, input logic [7:0] a, b);
      logic [63:0] ey, eh;
      logic        ec, edz;
      int          ee, cyc;
      model(8, f, {56'd0, a}, {56'd0, b}, ey, eh, ec, edz, ee);
      @(negedge clk);
      b8.start_in = 1; b8.f_in = f; b8.a_in = a; b8.b_in = b;
      @(posedge clk); #1;
      b8.start_in = 0;
      cyc = 0;
      while (!b8.done_out && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      check($sformatf("w8 latency f=%b", f), cyc, ee);
      check($sformatf("w8 y f=%b a=%h b=%h", f, a, b), b8.y_out, ey);
      check($sformatf("w8 hi f=%b a=%h b=%h", f, a, b), b8.hi_out, eh);
      check($sformatf("w8 c f=%b", f), b8.c_out, ec);
      check($sformatf("w8 dz f=%b", f), b8.dz_out, edz);
   endtask

   initial begin
      logic [3:0]  codes [10];
      logic [3:0]  f;
      logic [31:0] a, b;
      logic        done_seen;
      codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1010};
      b32.start_in = 0; b32.a_in = 0; b32.b_in = 0; b32.f_in = 0;
      b8.start_in = 0; b8.a_in = 0; b8.b_in = 0; b8.f_in = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst busy", b32.busy_out, 0);
      check("rst done", b32.done_out, 0);
      check("rst y", b32.y_out, 0);
      check("rst hi", b32.hi_out, 0);
      check("rst c", b32.c_out, 0);
      check("rst zero", b32.zero, 1);
      check("rst dz", b32.dz_out, 0);
      @(negedge clk);
      rst_n = 1;

      run32(4'b0110, 5, 7, -1, 1);
      run32(4'b0111, 5, 7, -1, 1);
      run32(4'b0011, 32'hFFFF_FFFF, 1, -1, 1);
      run32(4'b0010, 32'hFFFF_FFFF, 1, -1, 1);
      run32(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 1);
      run32(4'b1010, 100, 7, -1, 1);
      run32(4'b1010, 100, 0, -1, 1);
      run32(4'b1001, 123, 45, -1, 1);
      run32(4'b1000, 3, 5, -1, 0);
      run32(4'b0000, 32'hF0F0, 32'hFF00, -1, 1);

      // reset in the middle of a MULU, with a start offered during reset
      @(negedge clk);
      b32.start_in = 1; b32.f_in = 4'b1000; b32.a_in = 32'd123456; b32.b_in = 32'd789;
      @(posedge clk); #1;
      b32.start_in = 0;
      repeat (14) @(posedge clk);
      @(negedge clk);
      rst_n = 0; b32.start_in = 1; b32.f_in = 4'b0010; b32.a_in = 1; b32.b_in = 1;
      @(posedge clk); #1;
      check("midrst busy", b32.busy_out, 0);
      check("midrst y", b32.y_out, 0);
      check("midrst hi", b32.hi_out, 0);
      check("midrst zero", b32.zero, 1);
      check("midrst done", b32.done_out, 0);
      @(negedge clk);
      rst_n = 1; b32.start_in = 0;
      done_seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         done_seen |= b32.done_out;
      end
      check("no_done_after_rst", done_seen, 0);

      for (int i = 0; i < 50; i++) begin
         f = (i % 7 == 6) ? {1'b1, 3'($urandom)} : codes[$urandom_range(0, 9)];
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = 0;
            1: b = 32'($urandom_range(1, 15));
            2: b = a;
            default: b = $urandom;
         endcase
         run32(f, a, b, (i % 5 == 0) ? 3 : -1, 1);
      end

      run8(4'b1000, 8'd200, 8'd3);
      run8(4'b0111, 8'h80, 8'h7F);
      run8(4'b0011, 8'h80, 8'h7F);
      run8(4'b1010, 8'd250, 8'd9);
      for (int i = 0; i < 30; i++) begin
         f = codes[$urandom_range(0, 9)];
         run8(f, 8'($urandom), 8'($urandom_range(0, 255)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
